// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin arbiter.
// The master side drives req/done; the slave side (the arbiter) drives grant state.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output preempt
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for one shared 8:1 mux: the owner keeps the grant until done,
// abandon or a hold-watchdog preemption, with direct handoff to the next requester.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux8_rr_arbiter_if.slave    bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HW'(MAX_HOLD - 1) : '0;
  localparam bit WD_EN = (MAX_HOLD > 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_gnt;
  logic [7:0]    w_gnt_nxt;
  logic [2:0]    r_sel;
  logic [2:0]    w_sel_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_preempt;
  logic          w_preempt_nxt;
  logic [2:0]    r_ptr;
  logic [2:0]    w_ptr_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;

  logic [7:0]    w_mask;
  logic          w_wd_fire;
  logic          w_release;
  logic [2:0]    w_pick_idle;
  logic [2:0]    w_pick_hand;

  // First set bit of mask, scanning upward from start and wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [2:0] start, input logic [7:0] mask);
    logic [2:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // The owner is always r_sel while granted; its own bit is excluded from handoff.
  assign w_mask      = bus.req & ~(8'h01 << r_sel);
  assign w_pick_idle = pick(r_ptr, bus.req);
  assign w_pick_hand = pick(r_sel + 3'd1, w_mask);
  assign w_wd_fire   = WD_EN && (r_state == ST_GRANT) && (r_hold == HOLD_LAST)
                       && !bus.done && (w_mask != 8'h00);
  assign w_release   = bus.done || !bus.req[r_sel] || w_wd_fire;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_preempt_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (bus.req != 8'h00) begin
          w_gnt_nxt   = 8'h01 << w_pick_idle;
          w_sel_nxt   = w_pick_idle;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + 3'd1;
          if (w_mask != 8'h00) begin
            w_gnt_nxt     = 8'h01 << w_pick_hand;
            w_sel_nxt     = w_pick_hand;
            w_hold_nxt    = '0;
            w_preempt_nxt = w_wd_fire;
          end else begin
            w_gnt_nxt   = 8'h00;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_hold != HOLD_LAST) begin
          w_hold_nxt = r_hold + HW'(1);
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'h00;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Async reset clears the grant immediately, even mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 8'h00;
      r_sel     <= 3'd0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_ptr     <= 3'd0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.preempt = r_preempt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an ownership-level reference model.
module tb_mux8_rr_arbiter;
  localparam int MAXH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mux8_rr_arbiter_if bus_if ();

  mux8_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the resource, where the scan resumes, how long held.
  int         m_owner;
  int         m_ptr;
  int         m_held;
  int         m_sel;
  logic       m_pre;

  function automatic int mpick(input int start, input logic [7:0] m);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] rq, input logic dn);
    logic [7:0] others;
    logic       wd;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (rq != 8'h00) begin
        m_owner = mpick(m_ptr, rq);
        m_sel   = m_owner;
        m_held  = 0;
      end
    end else begin
      others = rq;
      others[m_owner] = 1'b0;
      wd = (MAXH > 0) && (m_held >= MAXH - 1) && !dn && (others != 8'h00);
      if (dn || !rq[m_owner] || wd) begin
        m_ptr = (m_owner + 1) % 8;
        if (others != 8'h00) begin
          m_owner = mpick(m_ptr, others);
          m_sel   = m_owner;
          m_held  = 0;
          m_pre   = wd;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advance and full-output comparison once per rising edge.
  initial begin
    logic [7:0] exp_gnt;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(bus_if.req, bus_if.done);
      #1;
      exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      chk("model_gnt",  bus_if.gnt, exp_gnt);
      chk("model_sel",  {5'd0, bus_if.sel}, 8'(m_sel));
      chk("model_busy", {7'd0, bus_if.busy}, {7'd0, (m_owner >= 0)});
      chk("model_pre",  {7'd0, bus_if.preempt}, {7'd0, m_pre});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req  = 8'h00;
    bus_if.done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.req  = 8'hFF;
    bus_if.done = 1'b0;

    // Reset with all requesting, then first grant to requester 0.
    tick();
    tick();
    chk("rst_gnt",  bus_if.gnt, 8'h00);
    chk("rst_sel",  {5'd0, bus_if.sel}, 8'h00);
    chk("rst_busy", {7'd0, bus_if.busy}, 8'h00);
    rst = 1'b0;
    tick();
    chk("first_gnt", bus_if.gnt, 8'h01);
    chk("first_sel", {5'd0, bus_if.sel}, 8'h00);

    // Rotation 0..7,0 without idle gaps.
    bus_if.done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rot_sel",  {5'd0, bus_if.sel}, 8'(k % 8));
      chk("rot_busy", {7'd0, bus_if.busy}, 8'h01);
    end

    // Advance to owner 6, then wrap/skip with req=05.
    for (int k = 0; k < 6; k++) tick();
    chk("own6_gnt", bus_if.gnt, 8'h40);
    bus_if.req = 8'h05;
    tick();
    chk("wrap_gnt", bus_if.gnt, 8'h01);
    tick();
    chk("skip_gnt", bus_if.gnt, 8'h04);
    chk("skip_sel", {5'd0, bus_if.sel}, 8'h02);

    // Watchdog preemption with a competitor pending.
    do_reset();
    bus_if.req = 8'h03;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wd_hold_gnt", bus_if.gnt, 8'h01);
      chk("wd_hold_pre", {7'd0, bus_if.preempt}, 8'h00);
    end
    tick();
    chk("wd_fire_gnt", bus_if.gnt, 8'h02);
    chk("wd_fire_pre", {7'd0, bus_if.preempt}, 8'h01);
    tick();
    chk("wd_pulse_end", {7'd0, bus_if.preempt}, 8'h00);

    // Lone owner is never preempted.
    do_reset();
    bus_if.req = 8'h01;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lone_gnt", bus_if.gnt, 8'h01);
      chk("lone_pre", {7'd0, bus_if.preempt}, 8'h00);
    end

    // Abandon returns to idle with sel held.
    do_reset();
    bus_if.req = 8'h08;
    tick();
    chk("ab_gnt", bus_if.gnt, 8'h08);
    bus_if.req = 8'h00;
    tick();
    chk("ab_idle_gnt",  bus_if.gnt, 8'h00);
    chk("ab_idle_busy", {7'd0, bus_if.busy}, 8'h00);
    chk("ab_idle_sel",  {5'd0, bus_if.sel}, 8'h03);

    // Asynchronous reset between edges while owner 4 holds.
    do_reset();
    bus_if.req = 8'h10;
    tick();
    chk("ar_gnt", bus_if.gnt, 8'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_async_gnt",  bus_if.gnt, 8'h00);
    chk("ar_async_busy", {7'd0, bus_if.busy}, 8'h00);
    tick();
    rst = 1'b0;
    bus_if.req = 8'hFF;
    tick();
    chk("ar_restart_gnt", bus_if.gnt, 8'h01);

    // Randomized traffic with occasional reset.
    bus_if.done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      case ($urandom_range(0, 3))
        0:       bus_if.req = 8'($urandom);
        1:       bus_if.req = 8'($urandom) & 8'($urandom);
        2:       bus_if.req = bus_if.req;
        default: bus_if.req = bus_if.req | 8'(1 << $urandom_range(0, 7));
      endcase
      bus_if.done = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
